// File: rtl/axi_regs_pkg.sv
// Register map, field layout and helpers shared by the SA AXI4-Lite register file.
// The map is kept here directly so every consumer sees one definition.
package axi_regs_pkg;

    localparam logic [31:0] REG_CONTROL    = 32'h000;
    localparam logic [31:0] REG_N          = 32'h004;
    localparam logic [31:0] REG_K          = 32'h008;
    localparam logic [31:0] REG_M          = 32'h00C;
    localparam logic [31:0] REG_TILE_SIZE  = 32'h010;
    localparam logic [31:0] REG_BLOCK_M    = 32'h014;
    localparam logic [31:0] REG_BASE_A     = 32'h018;
    localparam logic [31:0] REG_BASE_B     = 32'h01C;
    localparam logic [31:0] REG_BASE_C     = 32'h020;
    localparam logic [31:0] REG_STRIDE_A   = 32'h024;
    localparam logic [31:0] REG_STRIDE_B   = 32'h028;
    localparam logic [31:0] REG_STRIDE_C   = 32'h02C;
    localparam logic [31:0] REG_STATUS     = 32'h030;
    localparam logic [31:0] REG_READ_BASE  = 32'h040;
    localparam logic [31:0] REG_WRITE_BASE = 32'h044;

    localparam logic [31:0] DEFAULT_N         = 32'd16;
    localparam logic [31:0] DEFAULT_K         = 32'd16;
    localparam logic [31:0] DEFAULT_M         = 32'd16;
    localparam logic [31:0] DEFAULT_TILE_SIZE = 32'd4;
    localparam logic [31:0] DEFAULT_BLOCK_M   = 32'd4;

    localparam int NUM_CFG = 13;

    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_UPDATE_A_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT   = 2;
    localparam logic [31:0] CTRL_RD_MASK = 32'h0000_0006;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;
    localparam int STATUS_ERROR_BIT = 2;
    localparam logic [31:0] STATUS_RD_MASK = 32'h0000_0007;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // First field lands in the MSBs; cfg register index i maps to field i.
    typedef struct packed {
        logic [31:0] n;
        logic [31:0] k;
        logic [31:0] m;
        logic [31:0] tile_size;
        logic [31:0] block_m;
        logic [31:0] base_a;
        logic [31:0] base_b;
        logic [31:0] base_c;
        logic [31:0] stride_a;
        logic [31:0] stride_b;
        logic [31:0] stride_c;
        logic [31:0] read_base;
        logic [31:0] write_base;
    } sa_cfg_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } cfg_sel_t;

    function automatic sa_cfg_t cfg_default();
        sa_cfg_t c;
        c           = '0;
        c.n         = DEFAULT_N;
        c.k         = DEFAULT_K;
        c.m         = DEFAULT_M;
        c.tile_size = DEFAULT_TILE_SIZE;
        c.block_m   = DEFAULT_BLOCK_M;
        return c;
    endfunction

    function automatic logic [31:0] status_pack(input logic busy, input logic done, input logic error);
        logic [31:0] s;
        s                   = '0;
        s[STATUS_BUSY_BIT]  = busy;
        s[STATUS_DONE_BIT]  = done;
        s[STATUS_ERROR_BIT] = error;
        return s & STATUS_RD_MASK;
    endfunction

    // Word-aligned byte address -> config register index.
    function automatic cfg_sel_t cfg_decode(input logic [31:0] byte_addr);
        cfg_sel_t    s;
        logic [29:0] w;
        w = byte_addr[31:2];
        s = '0;
        if (w >= 30'd1 && w <= 30'd11) begin
            s.hit = 1'b1;
            s.idx = 4'(w - 30'd1);
        end else if (byte_addr == REG_READ_BASE) begin
            s.hit = 1'b1;
            s.idx = 4'd11;
        end else if (byte_addr == REG_WRITE_BASE) begin
            s.hit = 1'b1;
            s.idx = 4'd12;
        end
        return s;
    endfunction

endpackage

// File: rtl/sa_axil_wr_join.sv
// Joins independent AW and W beats into a single write commit and owns the B channel.
// Neither channel is accepted while a response is outstanding.
module sa_axil_wr_join #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [1:0]        commit_resp_i,
    output logic              commit_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       data_o,
    output logic [3:0]        strb_o
);

    logic              r_rst_done;
    logic              r_aw_full;
    logic              r_w_full;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [3:0]        r_strb;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_commit;

    assign s_axil_awready = r_rst_done & ~r_aw_full & ~r_bvalid;
    assign s_axil_wready  = r_rst_done & ~r_w_full & ~r_bvalid;
    assign w_aw_hs        = s_axil_awvalid & s_axil_awready;
    assign w_w_hs         = s_axil_wvalid & s_axil_wready;
    assign w_commit       = r_aw_full & r_w_full & ~r_bvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_done <= 1'b0;
            r_aw_full  <= 1'b0;
            r_w_full   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_addr     <= '0;
            r_data     <= '0;
            r_strb     <= '0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_addr    <= s_axil_awaddr;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_data   <= s_axil_wdata;
                r_strb   <= s_axil_wstrb;
            end
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= commit_resp_i;
            end else if (r_bvalid && s_axil_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    assign s_axil_bvalid = r_bvalid;
    assign s_axil_bresp  = r_bresp;
    assign commit_o      = w_commit;
    assign addr_o        = r_addr;
    assign data_o        = r_data;
    assign strb_o        = r_strb;

endmodule

// File: rtl/sa_axil_regs.sv
// AXI4-Lite control/status/config register file for the systolic-array engine:
// start pulse with config snapshot, sticky status bits and a level interrupt.
module sa_axil_regs
    import axi_regs_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [DATA_W-1:0] s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [DATA_W-1:0] s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic              start_o,
    output logic              update_a_o,
    output sa_cfg_t           cfg_o,
    input  logic              eng_busy_i,
    input  logic              eng_done_i,
    input  logic              eng_error_i,
    output logic              irq_o
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("sa_axil_regs supports DATA_W == 32 only");
    end

    localparam logic [NUM_CFG*32-1:0] CFG_DEF_FLAT = cfg_default();

    logic                    w_commit;
    logic [ADDR_W-1:0]       w_aw_addr;
    logic [31:0]             w_wdata;
    logic [3:0]              w_wstrb;
    logic [31:0]             w_aw_byte;
    logic [31:0]             w_ar_byte;
    cfg_sel_t                w_wsel;
    cfg_sel_t                w_rsel;
    logic                    w_wr_ctrl;
    logic                    w_wr_status;
    logic [1:0]              w_wr_resp;
    logic [31:0]             w_cfg_words [NUM_CFG];
    logic [NUM_CFG*32-1:0]   w_cfg_flat;
    logic                    w_ctrl_wr;
    logic                    w_status_wr;
    logic                    w_start_ok;
    logic                    w_start_rej;
    logic                    w_ar_hs;
    logic [31:0]             w_rd_data;
    logic [1:0]              w_rd_resp;
    logic                    w_unused_addr_lsb;

    logic                    r_rst_done;
    logic                    r_rvalid;
    logic [31:0]             r_rdata;
    logic [1:0]              r_rresp;
    logic                    r_update_a;
    logic                    r_irq_en;
    logic                    r_done;
    logic                    r_error;
    logic                    r_start;
    logic                    r_update_a_snap;
    sa_cfg_t                 r_cfg_snap;
    logic                    r_irq;

    sa_axil_wr_join #(.ADDR_W(ADDR_W)) u_wr_join (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .commit_resp_i  (w_wr_resp),
        .commit_o       (w_commit),
        .addr_o         (w_aw_addr),
        .data_o         (w_wdata),
        .strb_o         (w_wstrb)
    );

    assign w_unused_addr_lsb = ^{w_aw_addr[1:0], s_axil_araddr[1:0]};

    assign w_aw_byte   = 32'({w_aw_addr[ADDR_W-1:2], 2'b00});
    assign w_wsel      = cfg_decode(w_aw_byte);
    assign w_wr_ctrl   = (w_aw_byte == REG_CONTROL);
    assign w_wr_status = (w_aw_byte == REG_STATUS);
    assign w_wr_resp   = (w_wsel.hit || w_wr_ctrl || w_wr_status) ? RESP_OKAY : RESP_SLVERR;

    // Config words are byte-writable; cfg_o only follows them on an accepted start.
    for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
        logic [31:0] r_word;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_word <= CFG_DEF_FLAT[(NUM_CFG-1-gi)*32 +: 32];
            end else if (w_commit && w_wsel.hit && (w_wsel.idx == 4'(gi))) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_wstrb[b]) r_word[8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
        assign w_cfg_words[gi]                    = r_word;
        assign w_cfg_flat[(NUM_CFG-1-gi)*32 +: 32] = r_word;
    end

    assign w_ctrl_wr   = w_commit & w_wr_ctrl & w_wstrb[0];
    assign w_status_wr = w_commit & w_wr_status & w_wstrb[0];
    assign w_start_ok  = w_ctrl_wr & w_wdata[CTRL_START_BIT] & ~eng_busy_i;
    assign w_start_rej = w_ctrl_wr & w_wdata[CTRL_START_BIT] & eng_busy_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_update_a      <= 1'b0;
            r_irq_en        <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_start         <= 1'b0;
            r_update_a_snap <= 1'b0;
            r_cfg_snap      <= cfg_default();
            r_irq           <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_update_a <= w_wdata[CTRL_UPDATE_A_BIT];
                r_irq_en   <= w_wdata[CTRL_IRQ_EN_BIT];
            end
            r_start <= w_start_ok;
            if (w_start_ok) begin
                r_cfg_snap      <= sa_cfg_t'(w_cfg_flat);
                r_update_a_snap <= w_wdata[CTRL_UPDATE_A_BIT];
            end
            // Sticky bits: a set in the same cycle as a clear wins.
            r_done  <= eng_done_i |
                       (r_done & ~((w_status_wr & w_wdata[STATUS_DONE_BIT]) | w_start_ok));
            r_error <= eng_error_i | w_start_rej |
                       (r_error & ~(w_status_wr & w_wdata[STATUS_ERROR_BIT]));
            r_irq   <= r_irq_en & r_done;
        end
    end

    assign w_ar_byte      = 32'({s_axil_araddr[ADDR_W-1:2], 2'b00});
    assign w_rsel         = cfg_decode(w_ar_byte);
    assign s_axil_arready = r_rst_done & ~r_rvalid;
    assign w_ar_hs        = s_axil_arvalid & s_axil_arready;

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        if (w_ar_byte == REG_CONTROL) begin
            w_rd_data[CTRL_UPDATE_A_BIT] = r_update_a;
            w_rd_data[CTRL_IRQ_EN_BIT]   = r_irq_en;
            w_rd_data                    = w_rd_data & CTRL_RD_MASK;
        end else if (w_ar_byte == REG_STATUS) begin
            w_rd_data = status_pack(eng_busy_i, r_done, r_error);
        end else if (w_rsel.hit) begin
            w_rd_data = w_cfg_words[w_rsel.idx];
        end else begin
            w_rd_resp = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_done <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= 2'b00;
        end else begin
            r_rst_done <= 1'b1;
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end else if (r_rvalid && s_axil_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axil_rvalid = r_rvalid;
    assign s_axil_rdata  = r_rdata;
    assign s_axil_rresp  = r_rresp;
    assign start_o       = r_start;
    assign update_a_o    = r_update_a_snap;
    assign cfg_o         = r_cfg_snap;
    assign irq_o         = r_irq;

endmodule

// File: tb/tb_sa_axil_regs.sv
// Directed bench for sa_axil_regs: AXI-Lite writes/reads, start/snapshot,
// sticky status with W1C, interrupt and unmapped-address handling.
module tb_sa_axil_regs;
    import axi_regs_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [11:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        start_o;
    logic        update_a_o;
    sa_cfg_t     cfg_o;
    logic        eng_busy_i = 1'b0;
    logic        eng_done_i = 1'b0;
    logic        eng_error_i = 1'b0;
    logic        irq_o;

    int          n_checks = 0;
    int          n_fail = 0;
    int          start_cnt = 0;
    logic [31:0] start_k = '0;
    logic        start_b = 1'b0;

    always #5 clk = ~clk;

    sa_axil_regs #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .start_o        (start_o),
        .update_a_o     (update_a_o),
        .cfg_o          (cfg_o),
        .eng_busy_i     (eng_busy_i),
        .eng_done_i     (eng_done_i),
        .eng_error_i    (eng_error_i),
        .irq_o          (irq_o)
    );

    always @(negedge clk) begin
        if (start_o) begin
            start_cnt <= start_cnt + 1;
            start_k   <= cfg_o.k;
            start_b   <= bvalid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // AW is raised w_lead cycles after W; optionally pulses eng_done_i on the commit edge.
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead, input logic done_on_commit, input logic [1:0] exp_resp);
        logic aw_done = 1'b0;
        logic w_done = 1'b0;
        logic aw_hs, w_hs;
        logic [1:0] resp = 2'b11;
        int cyc = 0;
        int b_cycles = 0;
        wdata = d; wstrb = s; wvalid = 1'b1; awaddr = a;
        awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_hs = awvalid & awready;
            w_hs  = wvalid & wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid = 1'b0;  w_done = 1'b1;  end
            if (!aw_done && cyc >= w_lead) awvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_accept", 32'({aw_done, w_done}), 32'd3);
        eng_done_i = done_on_commit;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            eng_done_i = 1'b0;
            if (bvalid) begin b_cycles++; resp = bresp; end
        end
        check("b_count", 32'(b_cycles), 32'd1);
        check("bresp", 32'(resp), 32'(exp_resp));
        $display("WR addr=0x%03h data=0x%08h strb=%b bresp=%b", a, d, s, resp);
    endtask

    // rready is held low for hold cycles after rvalid, checking the beat stays put.
    task automatic axi_read(input logic [11:0] a, input int hold,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic hs = 1'b0;
        int cyc = 0;
        araddr = a; arvalid = 1'b1;
        while (!hs && cyc < 20) begin
            hs = arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        check("ar_accept", 32'(hs), 32'd1);
        cyc = 0;
        while (!rvalid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rvalid", 32'(rvalid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_rdata", rdata, exp_data);
            check("hold_arready", 32'({arready, rvalid}), 32'd1);
        end
        check("rdata", rdata, exp_data);
        check("rresp", 32'(rresp), 32'(exp_resp));
        $display("RD addr=0x%03h rdata=0x%08h rresp=%b", a, rdata, rresp);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_valids", 32'({bvalid, rvalid, start_o, irq_o}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'({awready, wready, arready}), 32'd7);
        check("cfg_n_def", cfg_o.n, 32'd16);
        check("cfg_k_def", cfg_o.k, 32'd16);
        check("cfg_tile_def", cfg_o.tile_size, 32'd4);
        check("cfg_base_a_def", cfg_o.base_a, 32'd0);
        check("cfg_wbase_def", cfg_o.write_base, 32'd0);
        check("irq_def", 32'(irq_o), 32'd0);
        axi_read(12'h004, 0, 32'd16, RESP_OKAY);
        axi_read(12'h030, 0, 32'd0, RESP_OKAY);

        // W leads AW, then a partial-strobe write
        axi_write(12'h008, 32'h0000_0040, 4'hF, 3, 1'b0, RESP_OKAY);
        axi_read(12'h008, 0, 32'h0000_0040, RESP_OKAY);
        axi_write(12'h008, 32'hFFFF_1234, 4'b0011, 0, 1'b0, RESP_OKAY);
        axi_read(12'h008, 0, 32'h0000_1234, RESP_OKAY);

        // Accepted start snapshots K=0x40
        axi_write(12'h008, 32'h0000_0040, 4'hF, 0, 1'b0, RESP_OKAY);
        sc = start_cnt;
        axi_write(12'h000, 32'h0000_0005, 4'hF, 0, 1'b0, RESP_OKAY);
        check("start_pulses", 32'(start_cnt - sc), 32'd1);
        check("start_with_b", 32'(start_b), 32'd1);
        check("start_cfg_k", start_k, 32'h40);
        check("update_a_0", 32'(update_a_o), 32'd0);
        axi_read(12'h000, 0, 32'h0000_0004, RESP_OKAY);
        eng_busy_i = 1'b1;
        axi_write(12'h008, 32'h0000_0080, 4'hF, 1, 1'b0, RESP_OKAY);
        check("cfg_k_held", cfg_o.k, 32'h40);
        axi_read(12'h008, 0, 32'h0000_0080, RESP_OKAY);
        eng_busy_i = 1'b0;
        sc = start_cnt;
        axi_write(12'h000, 32'h0000_0007, 4'hF, 0, 1'b0, RESP_OKAY);
        check("start2_pulses", 32'(start_cnt - sc), 32'd1);
        check("start2_cfg_k", cfg_o.k, 32'h80);
        check("update_a_1", 32'(update_a_o), 32'd1);
        axi_read(12'h000, 0, 32'h0000_0006, RESP_OKAY);

        // DONE sticky, irq latency, W1C, set-wins
        eng_done_i = 1'b1;
        @(posedge clk); #1;
        eng_done_i = 1'b0;
        check("irq_lag", 32'(irq_o), 32'd0);
        @(posedge clk); #1;
        check("irq_set", 32'(irq_o), 32'd1);
        axi_read(12'h030, 0, 32'h0000_0002, RESP_OKAY);
        axi_write(12'h030, 32'h0000_0002, 4'hF, 0, 1'b0, RESP_OKAY);
        axi_read(12'h030, 0, 32'h0000_0000, RESP_OKAY);
        check("irq_clr", 32'(irq_o), 32'd0);
        axi_write(12'h030, 32'h0000_0002, 4'hF, 0, 1'b1, RESP_OKAY);
        axi_read(12'h030, 0, 32'h0000_0002, RESP_OKAY);
        check("irq_set_wins", 32'(irq_o), 32'd1);
        axi_write(12'h030, 32'h0000_0003, 4'hF, 0, 1'b0, RESP_OKAY);
        axi_read(12'h030, 0, 32'h0000_0000, RESP_OKAY);

        // Rejected start while busy
        eng_busy_i = 1'b1;
        sc = start_cnt;
        axi_write(12'h000, 32'h0000_0001, 4'hF, 0, 1'b0, RESP_OKAY);
        check("rej_no_start", 32'(start_cnt - sc), 32'd0);
        axi_read(12'h030, 0, 32'h0000_0005, RESP_OKAY);
        axi_read(12'h000, 0, 32'h0000_0000, RESP_OKAY);
        axi_write(12'h030, 32'h0000_0004, 4'hF, 0, 1'b0, RESP_OKAY);
        axi_read(12'h030, 0, 32'h0000_0001, RESP_OKAY);
        eng_busy_i = 1'b0;
        eng_error_i = 1'b1;
        @(posedge clk); #1;
        eng_error_i = 1'b0;
        axi_read(12'h030, 0, 32'h0000_0004, RESP_OKAY);
        axi_write(12'h030, 32'h0000_0004, 4'hF, 0, 1'b0, RESP_OKAY);

        // Unmapped address
        axi_write(12'hFFC, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, RESP_SLVERR);
        axi_read(12'hFFC, 5, 32'h0000_0000, RESP_SLVERR);
        axi_read(12'h004, 0, 32'd16, RESP_OKAY);
        axi_read(12'h008, 0, 32'h0000_0080, RESP_OKAY);
        axi_read(12'h030, 0, 32'h0000_0000, RESP_OKAY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_axil_regs.md
Name: sa_axil_regs

Overview:
- AXI4-Lite slave register file for the systolic-array accelerator. Implements the control/status/configuration map defined in axi_regs_pkg.
- Sits between the PS interconnect and the SA control engine.
- Generates the start pulse, holds a stable config snapshot for the engine, and collects busy/done/error into status and interrupt.

Parameters:
- ADDR_W, 12, AXI-Lite address width. Decode uses bits [ADDR_W-1:2]; bits [1:0] are ignored.
- DATA_W, 32, data width; only 32 is supported (elaboration assert).

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- s_axil_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel
- s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
- s_axil_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel
- start_o  out  1  one-cycle start pulse to engine
- update_a_o  out  1  UPDATE_A value captured with start
- cfg_o  out  $bits(sa_cfg_t)  config snapshot taken at start
- eng_busy_i  in  1  engine busy (level)
- eng_done_i  in  1  engine done (one-cycle pulse)
- eng_error_i  in  1  engine error (one-cycle pulse)
- irq_o  out  1  registered interrupt, level

Behaviour:
- Reset:
  - awready/wready/arready=0 during rst, 1 the cycle after.
  - bvalid/rvalid/start_o/irq_o=0; bresp/rresp/rdata=0.
  - Config registers = DEFAULT_* (BASE/STRIDE/READ_BASE/WRITE_BASE=0); cfg_o = same defaults; CONTROL and STATUS = 0.
- rst mid-transaction aborts all channels; no response is issued.
- Write path:
  - AW and W are captured independently into holding regs. awready=1 while AW holding is empty and bvalid=0; likewise for wready.
  - When both are held, the write commits on the next edge, bvalid rises the same edge, and both holds clear.
  - bvalid stays high until bready; no new commit while bvalid=1.
  - wstrb is honoured per byte on data registers.
- Read path:
  - arready=1 when rvalid=0.
  - On handshake, rdata/rresp are registered and rvalid rises the next cycle.
  - rdata/rresp are stable until rready.
- Unmapped address: write discarded with bresp=SLVERR (2'b10); read returns rdata=0, rresp=SLVERR. OKAY=2'b00 otherwise.
- CONTROL:
  - START is write-1-to-trigger and reads 0; UPDATE_A and IRQ_EN are stored levels.
  - Accepted start (START=1 and eng_busy_i=0 at commit): start_o=1 for exactly the cycle after commit. On that same edge, cfg_o <= current register values, update_a_o <= new UPDATE_A, and STATUS.DONE is cleared.
  - START with eng_busy_i=1: no pulse, STATUS.ERROR set, bresp=OKAY; the other CONTROL bits are still written.
- STATUS (REG_STATUS):
  - BUSY = live eng_busy_i.
  - DONE is sticky, set by eng_done_i.
  - ERROR is sticky, set by eng_error_i or a rejected start.
  - DONE/ERROR are W1C. A set and a clear in the same cycle: set wins. BUSY write is ignored.
- Config registers are read/write at any time. A write while busy does not affect cfg_o until the next accepted start.
- irq_o <= IRQ_EN & DONE (one-cycle registered latency).

Decomposition:
- Add to axi_regs_pkg:
  - REG_STATUS (next free word after REG_STRIDE_C, added to addr_map.svh).
  - sa_cfg_t packed struct with 32-bit fields n, k, m, tile_size, block_m, base_a/b/c, stride_a/b/c, read_base, write_base.
  - RESP_OKAY / RESP_SLVERR constants.
  - A cfg_default() function returning DEFAULT_* values.
- Use the package's status_pack and mask constants for STATUS/CONTROL readback.
- One sub-module, sa_axil_wr_join: AW/W holding registers and commit/bvalid logic.

Test Plan:
- Reset, then read REG_N, REG_STATUS -> rdata=DEFAULT_N then 0, rresp=OKAY, irq_o=0, cfg_o=cfg_default().
- W valid 3 cycles before AW, write REG_K=0x40 -> exactly one B with OKAY, readback 0x40. Then wstrb=4'b0011, data 0xFFFF_1234 -> readback 0x0000_1234.
- REG_K=0x40, eng_busy_i=0, write CONTROL=START|IRQ_EN -> start_o high exactly 1 cycle the cycle after commit, with cfg_o.k=0x40. CONTROL readback has START=0, IRQ_EN=1. Write REG_K=0x80 while busy -> cfg_o.k stays 0x40.
- eng_done_i pulse -> STATUS.DONE=1, irq_o=1 one cycle later. W1C DONE -> irq_o=0. eng_done_i in the same cycle as W1C commit -> DONE remains 1.
- eng_busy_i=1, write CONTROL=START -> no start_o, STATUS.ERROR=1, BUSY=1, bresp=OKAY. W1C ERROR -> ERROR=0.
- Write/read address 0xFFC -> bresp=SLVERR, rresp=SLVERR, rdata=0, no register change. rready held low 5 cycles -> rdata stable, arready=0 throughout.
